rv_instr_encoder_loader: RTL and testbench

- Inverse of the instruction field decoder: takes RV32I instruction fields (op, fun3, fun7, rd, rs1, rs2, full immediate), packs them into a 32-bit instruction word per the opcode's format, and writes consecutive words into instruction memory.
- Sits in the test framework between the stimulus/program source and the instruction-memory write port; lets the framework load programs into the single-cycle CPU before releasing it from reset.
- Valid/ready on input, single-entry output register with memory-side stall.

---
 rtl/rv_isa_pkg.sv | 31 +++
 rtl/rv_instr_pack.sv | 61 ++++++
 rtl/rv_instr_encoder_loader.sv | 110 +++++++++++
 tb/tb_rv_instr_encoder_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I opcode constants, instruction format and loader state types shared by encoder and decoder.
package rv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYS    = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL} fmt_e;

  typedef enum logic [1:0] {StIdle, StLoad, StDone} ld_state_e;

  function automatic fmt_e op_fmt(input logic [6:0] op);
    case (op)
      OP_R:                            return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: return FMT_I;
      OP_STORE:                        return FMT_S;
      OP_BRANCH:                       return FMT_B;
      OP_LUI, OP_AUIPC:                return FMT_U;
      OP_JAL:                          return FMT_J;
      default:                         return FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/rv_instr_pack.sv
// Combinational RV32I field packer. ENC_IMM_RANGE_CHECK_EN flags immediates that the
// format cannot represent; otherwise excess immediate bits are truncated.
module rv_instr_pack
  import rv_isa_pkg::*;
(
  input  logic [6:0]  op,
  input  logic [2:0]  fun3,
  input  logic [6:0]  fun7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  fmt_e fmt;
  logic shift;

  assign fmt   = op_fmt(op);
  assign shift = (op == OP_IMM) && ((fun3 == 3'b001) || (fun3 == 3'b101));

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (fmt)
      FMT_R: word = {fun7, rs2, rs1, fun3, rd, op};
      FMT_I: word = shift ? {fun7, imm[4:0], rs1, fun3, rd, op}
                          : {imm[11:0], rs1, fun3, rd, op};
      FMT_S: word = {imm[11:5], rs2, rs1, fun3, imm[4:0], op};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, fun3, imm[4:1], imm[11], op};
      FMT_U: word = {imm[31:12], rd, op};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default: illegal = 1'b1;
    endcase
  end

`ifdef ENC_IMM_RANGE_CHECK_EN
  // Upper bits must be a pure sign extension of the top encodable bit.
  logic sx12, sx13, sx21;
  assign sx12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign sx13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign sx21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    range_err = 1'b0;
    case (fmt)
      FMT_I:   range_err = shift ? (|imm[31:5]) : !sx12;
      FMT_S:   range_err = !sx12;
      FMT_B:   range_err = !sx13 || imm[0];
      FMT_U:   range_err = |imm[11:0];
      FMT_J:   range_err = !sx21 || imm[0];
      default: range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/rv_instr_encoder_loader.sv
// Encodes RV32I field bundles and streams them into instruction memory through a
// single-entry output register. Optional immediate range checking: ENC_IMM_RANGE_CHECK_EN.
module rv_instr_encoder_loader
  import rv_isa_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_last,
  input  logic [6:0]                 op,
  input  logic [2:0]                 fun3,
  input  logic [6:0]                 fun7,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [31:0]                imm,
  output logic                       imem_we,
  input  logic                       imem_ready,
  output logic [31:0]                imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] word_count,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  ld_state_e   state;
  logic        last_acc;
  logic [31:0] word;
  logic        illegal, range_err, good;
  logic        accept, commit, we_next;
  logic [CW-1:0] cnt_next;

  rv_instr_pack u_pack (
    .op        (op),
    .fun3      (fun3),
    .fun7      (fun7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .word      (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  // The pending word counts against DEPTH so a full session never over-accepts.
  assign in_ready = (state == StLoad) && !last_acc &&
                    ((32'(word_count) + 32'(imem_we)) < DEPTH) &&
                    (!imem_we || imem_ready);
  assign accept   = in_valid && in_ready;
  assign commit   = imem_we && imem_ready;
  assign good     = !illegal && !range_err;
  assign we_next  = (imem_we && !imem_ready) || (accept && good);
  assign cnt_next = word_count + CW'(commit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      last_acc   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        StLoad: begin
          if (accept) begin
            if (good) imem_wdata <= word;
            else      err        <= 1'b1;
            if (in_last) last_acc <= 1'b1;
          end
          imem_we <= we_next;
          if (commit) begin
            imem_addr  <= imem_addr + 32'd4;
            word_count <= cnt_next;
          end
          if ((last_acc && !we_next) || (32'(cnt_next) == DEPTH)) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state      <= StLoad;
            last_acc   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_instr_encoder_loader.sv
// Directed bench for rv_instr_encoder_loader with a write scoreboard; a second DEPTH=2 instance
// exercises the full-session path.
module tb_rv_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_last;
  logic [6:0]  op, fun7;
  logic [2:0]  fun3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm;
  logic        imem_we, imem_ready;
  logic [31:0] imem_addr, imem_wdata;
  logic [8:0]  word_count;
  logic        busy, done, err;

  logic        d2_start, d2_in_valid, d2_in_ready, d2_imem_we, d2_busy, d2_done, d2_err;
  logic [31:0] d2_imem_addr, d2_imem_wdata;
  logic [1:0]  d2_word_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [31:0] exp_addr;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  always #5 clk = ~clk;

  rv_instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .op(op), .fun3(fun3), .fun7(fun7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .word_count(word_count), .busy(busy), .done(done), .err(err)
  );

  rv_instr_encoder_loader #(.BASE_ADDR(32'h0), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(d2_start), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_last(1'b0), .op(7'b0010011), .fun3(3'b000), .fun7(7'b0), .rd(5'd1), .rs1(5'd0),
    .rs2(5'd0), .imm(32'd5), .imem_we(d2_imem_we), .imem_ready(1'b1),
    .imem_addr(d2_imem_addr), .imem_wdata(d2_imem_wdata), .word_count(d2_word_count),
    .busy(d2_busy), .done(d2_done), .err(d2_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Commit monitor: every write must match the oldest expected entry; stalls must hold steady.
  always @(negedge clk) begin
    if (prev_stall) begin
      chk("stall_we", 32'(imem_we), 32'd1);
      chk("stall_addr", imem_addr, prev_addr);
      chk("stall_data", imem_wdata, prev_data);
    end
    if (imem_we && imem_ready && !rst) begin
      chk("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        logic [63:0] e;
        e = sb.pop_front();
        chk("write_addr", imem_addr, e[63:32]);
        chk("write_data", imem_wdata, e[31:0]);
      end
    end
    prev_stall = imem_we && !imem_ready && !rst;
    prev_addr  = imem_addr;
    prev_data  = imem_wdata;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_addr = 32'h0;
  endtask

  task automatic send(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic last, input logic ok,
                      input logic [31:0] w);
    logic got;
    op = o; fun3 = f3; fun7 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_last = last; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
    end
    #1 in_valid = 1'b0; in_last = 1'b0;
    chk("accept", 32'(got), 32'd1);
    if (got && ok) begin
      sb.push_back({exp_addr, w});
      exp_addr += 32'd4;
    end
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done", 32'(seen), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, com;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; imem_ready = 1'b1;
    op = '0; fun3 = '0; fun7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    d2_start = 1'b0; d2_in_valid = 1'b0; exp_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    chk("rst_count", 32'(word_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;

    // addi / add / sw program
    pulse_start();
    @(negedge clk);
    chk("busy_load", 32'(busy), 32'd1);
    @(posedge clk); #1;
    send(7'b0010011, 3'b000, 7'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
    send(7'b0110011, 3'b000, 7'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
    send(7'b0100011, 3'b010, 7'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 1'b1, 32'h0020A423);
    wait_done();
    chk("t1_count", 32'(word_count), 32'd3);
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // restart from DONE; B/U/J formats, memory stall, illegal opcode mid-stream
    pulse_start();
    @(negedge clk);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_count", 32'(word_count), 32'd0);
    chk("restart_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    send(7'b1100011, 3'b000, 7'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'hFE208EE3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_we", 32'(imem_we), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_hold_data", imem_wdata, 32'hFE208EE3);
    end
    imem_ready = 1'b1;
    @(posedge clk); #1;
    send(7'b0110111, 3'b000, 7'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 1'b1, 32'h123452B7);
    send(7'b1111111, 3'b000, 7'b0, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 32'h0);
    send(7'b1101111, 3'b000, 7'b0, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 1'b1, 32'h008000EF);
    wait_done();
    chk("t2_err", 32'(err), 32'd1);
    chk("t2_count", 32'(word_count), 32'd3);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // reset while a write is stalled
    pulse_start();
    @(negedge clk);
    chk("t3_err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
    send(7'b0010011, 3'b000, 7'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 1'b1, 32'h00500093);
    @(posedge clk); #1;
    imem_ready = 1'b0;
    send(7'b0110011, 3'b000, 7'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 1'b1, 32'h002081B3);
    @(negedge clk);
    chk("t3_pre_count", 32'(word_count), 32'd1);
    chk("t3_pre_we", 32'(imem_we), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t3_we", 32'(imem_we), 32'd0);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_count", 32'(word_count), 32'd0);
    chk("t3_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_no_write", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // shift encoding and an oversized addi immediate
    pulse_start();
    send(7'b0010011, 3'b101, 7'b0100000, 5'd1, 5'd1, 5'd0, 32'd3, 1'b0, 1'b1, 32'h4030D093);
`ifdef ENC_IMM_RANGE_CHECK_EN
    send(7'b0010011, 3'b000, 7'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 1'b0, 32'h0);
    wait_done();
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_count", 32'(word_count), 32'd1);
`else
    send(7'b0010011, 3'b000, 7'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, 1'b1, 32'h00000093);
    wait_done();
    chk("t4_err", 32'(err), 32'd0);
    chk("t4_count", 32'(word_count), 32'd2);
`endif
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;

    // DEPTH=2 instance: three bundles offered, only two accepted
    d2_start = 1'b1;
    @(posedge clk); #1 d2_start = 1'b0;
    d2_in_valid = 1'b1;
    acc = 0; com = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (d2_in_valid && d2_in_ready) acc++;
      if (d2_imem_we) begin
        chk("d2_addr", d2_imem_addr, 32'(com * 4));
        chk("d2_data", d2_imem_wdata, 32'h00500093);
        com++;
      end
    end
    chk("d2_accepts", 32'(acc), 32'd2);
    chk("d2_commits", 32'(com), 32'd2);
    chk("d2_done", 32'(d2_done), 32'd1);
    chk("d2_count", 32'(d2_word_count), 32'd2);
    chk("d2_in_ready", 32'(d2_in_ready), 32'd0);
    chk("d2_err", 32'(d2_err), 32'd0);
    d2_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
